wb_commit_queue: RTL

- Parametrised writeback/commit stage for the LoongArch-style 5-stage pipeline; sits between the MEM stage and the register file / CSR unit.
- Replaces the single-register WB stage with a DEPTH-entry in-order commit queue, so the MEM stage is not back-pressured while the head is stalled.
- Retires at most one entry per cycle and resolves exceptions, ERTN and refetch at the head.
- Exports a pending-write scoreboard for ID hazard checks.

---
 rtl/wb_commit_queue_if.sv | 54 +++++
 rtl/wb_commit_queue.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/wb_commit_queue_if.sv
// Bundle of MEM-to-WB entry, commit, scoreboard, trace and perf signals for wb_commit_queue.
// The slave modport is the commit queue; the master modport is the surrounding pipeline.
interface wb_commit_queue_if #(
    parameter int XLEN   = 32,
    parameter int NEXC   = 14,
    parameter int EIDX_W = 4
);
    logic              ms_to_ws_valid;
    logic              ws_allowin;
    logic [XLEN-1:0]   ms_pc;
    logic              ms_rf_we;
    logic [4:0]        ms_rf_waddr;
    logic [XLEN-1:0]   ms_rf_wdata;
    logic              ms_csr_re;
    logic [NEXC-1:0]   ms_exc_vec;
    logic              ms_ertn;
    logic              ms_refetch;
    logic [XLEN-1:0]   ms_vaddr;
    logic              ws_hold;
    logic [XLEN-1:0]   csr_rvalue;
    logic              csr_re;
    logic              ws_rf_we;
    logic [4:0]        ws_rf_waddr;
    logic [XLEN-1:0]   ws_rf_wdata;
    logic              wb_ex;
    logic [EIDX_W-1:0] wb_exc_idx;
    logic [XLEN-1:0]   wb_pc;
    logic [XLEN-1:0]   wb_vaddr;
    logic              ertn_flush;
    logic              wb_refetch_flush;
    logic [31:0]       ws_pend_mask;
    logic [XLEN-1:0]   debug_wb_pc;
    logic [3:0]        debug_wb_rf_we;
    logic [4:0]        debug_wb_rf_wnum;
    logic [XLEN-1:0]   debug_wb_rf_wdata;
    logic [31:0]       perf_retire_cnt;
    logic [31:0]       perf_exc_cnt;

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata, ms_csr_re,
               ms_exc_vec, ms_ertn, ms_refetch, ms_vaddr, ws_hold, csr_rvalue,
        output ws_allowin, csr_re, ws_rf_we, ws_rf_waddr, ws_rf_wdata, wb_ex, wb_exc_idx,
               wb_pc, wb_vaddr, ertn_flush, wb_refetch_flush, ws_pend_mask, debug_wb_pc,
               debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, perf_retire_cnt, perf_exc_cnt
    );

    modport master (
        output ms_to_ws_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata, ms_csr_re,
               ms_exc_vec, ms_ertn, ms_refetch, ms_vaddr, ws_hold, csr_rvalue,
        input  ws_allowin, csr_re, ws_rf_we, ws_rf_waddr, ws_rf_wdata, wb_ex, wb_exc_idx,
               wb_pc, wb_vaddr, ertn_flush, wb_refetch_flush, ws_pend_mask, debug_wb_pc,
               debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, perf_retire_cnt, perf_exc_cnt
    );
endinterface

// File: rtl/wb_commit_queue.sv
// DEPTH-entry in-order writeback/commit queue; retires one entry per cycle and resolves exceptions/ERTN/refetch at the head.
// Define WB_PERF_CNT_EN to build the retire/exception performance counters (otherwise those ports read 0).
module wb_commit_queue #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2,
    parameter int NEXC   = 14,
    parameter int EIDX_W = 4
) (
    input logic              clk,
    input logic              resetn,
    wb_commit_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] r_pc      [DEPTH];
    logic            r_rf_we   [DEPTH];
    logic [4:0]      r_waddr   [DEPTH];
    logic [XLEN-1:0] r_wdata   [DEPTH];
    logic            r_csr_re  [DEPTH];
    logic [NEXC-1:0] r_exc     [DEPTH];
    logic            r_ertn    [DEPTH];
    logic            r_refetch [DEPTH];
    logic [XLEN-1:0] r_vaddr   [DEPTH];

    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_valid;

    logic w_head_v, w_fire, w_has_ex, w_flush, w_allowin, w_enq;
    logic w_h_ertn, w_h_refetch, w_h_rf_we, w_h_csr_re;
    logic [31:0] w_pend;

    // Lowest set bit of the exception vector wins; an empty vector encodes as 0.
    function automatic logic [EIDX_W-1:0] f_exc_idx(input logic [NEXC-1:0] vec);
        logic [EIDX_W-1:0] idx;
        idx = {EIDX_W{1'b0}};
        for (int i = NEXC - 1; i >= 0; i--) begin
            idx = vec[i] ? EIDX_W'(i) : idx;
        end
        return idx;
    endfunction

    assign w_head_v    = (r_count != {CW{1'b0}});
    assign w_fire      = w_head_v & ~bus.ws_hold;
    assign w_has_ex    = w_head_v & (|r_exc[r_rd_ptr]);
    assign w_h_ertn    = w_head_v & r_ertn[r_rd_ptr];
    assign w_h_refetch = w_head_v & r_refetch[r_rd_ptr];
    assign w_h_rf_we   = w_head_v & r_rf_we[r_rd_ptr];
    assign w_h_csr_re  = w_head_v & r_csr_re[r_rd_ptr];
    assign w_flush     = w_fire & (w_has_ex | w_h_ertn | w_h_refetch);
    assign w_allowin   = (r_count < CW'(DEPTH)) & ~w_flush;
    assign w_enq       = bus.ms_to_ws_valid & w_allowin;

    assign bus.ws_allowin       = w_allowin;
    assign bus.wb_ex            = w_fire & w_has_ex;
    assign bus.ertn_flush       = w_fire & w_h_ertn & ~w_has_ex;
    assign bus.wb_refetch_flush = w_fire & w_h_refetch & ~w_has_ex & ~w_h_ertn;
    assign bus.ws_rf_we         = w_fire & w_h_rf_we & ~w_has_ex;
    assign bus.csr_re           = w_fire & w_h_csr_re;
    assign bus.ws_rf_wdata      = ~w_head_v ? {XLEN{1'b0}} :
                                  (w_h_csr_re ? bus.csr_rvalue : r_wdata[r_rd_ptr]);
    assign bus.wb_pc            = w_head_v ? r_pc[r_rd_ptr]    : {XLEN{1'b0}};
    assign bus.wb_vaddr         = w_head_v ? r_vaddr[r_rd_ptr] : {XLEN{1'b0}};
    assign bus.ws_rf_waddr      = w_head_v ? r_waddr[r_rd_ptr] : 5'd0;
    assign bus.wb_exc_idx       = w_head_v ? f_exc_idx(r_exc[r_rd_ptr]) : {EIDX_W{1'b0}};

    assign bus.debug_wb_pc       = bus.wb_pc;
    assign bus.debug_wb_rf_we    = {4{bus.ws_rf_we}};
    assign bus.debug_wb_rf_wnum  = bus.ws_rf_waddr;
    assign bus.debug_wb_rf_wdata = bus.ws_rf_wdata;

    // Pending-write scoreboard; excepting entries still count, GPR 0 never does.
    always_comb begin
        w_pend = 32'h0000_0000;
        for (int i = 0; i < DEPTH; i++) begin
            w_pend = w_pend | ((r_valid[i] & r_rf_we[i]) ? (32'h0000_0001 << r_waddr[i]) : 32'h0000_0000);
        end
        w_pend[0] = 1'b0;
    end
    assign bus.ws_pend_mask = w_pend;

    // Pointer, occupancy and valid-bit bookkeeping; a flush empties the queue at the next edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_valid  <= {DEPTH{1'b0}};
        end else if (w_flush) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_valid  <= {DEPTH{1'b0}};
        end else begin
            if (w_enq) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            if (w_fire) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload capture; contents are only observed through r_valid/r_count, so no reset.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pc[r_wr_ptr]      <= bus.ms_pc;
            r_rf_we[r_wr_ptr]   <= bus.ms_rf_we;
            r_waddr[r_wr_ptr]   <= bus.ms_rf_waddr;
            r_wdata[r_wr_ptr]   <= bus.ms_rf_wdata;
            r_csr_re[r_wr_ptr]  <= bus.ms_csr_re;
            r_exc[r_wr_ptr]     <= bus.ms_exc_vec;
            r_ertn[r_wr_ptr]    <= bus.ms_ertn;
            r_refetch[r_wr_ptr] <= bus.ms_refetch;
            r_vaddr[r_wr_ptr]   <= bus.ms_vaddr;
        end
    end

`ifdef WB_PERF_CNT_EN
    logic [31:0] r_perf_retire;
    logic [31:0] r_perf_exc;

    // Retire and committed-exception counters, free-running with natural wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_retire <= 32'd0;
            r_perf_exc    <= 32'd0;
        end else begin
            if (w_fire) begin
                r_perf_retire <= r_perf_retire + 32'd1;
            end
            if (w_fire & w_has_ex) begin
                r_perf_exc <= r_perf_exc + 32'd1;
            end
        end
    end
    assign bus.perf_retire_cnt = r_perf_retire;
    assign bus.perf_exc_cnt    = r_perf_exc;
`else
    assign bus.perf_retire_cnt = 32'd0;
    assign bus.perf_exc_cnt    = 32'd0;
`endif
endmodule
